// File: rtl/gpio_csr.sv
// gpio_csr: memory-mapped GPIO block with NUM_PORTS ports of GPIO_WIDTH bits.
// Each port occupies 16 bytes starting at BASE_ADDR + 16*p:
//   +0x0 OUT (RW), +0x4 IN (RO), +0x8 IRQ_EN (RW), +0xC IRQ_PEND (RW1C).
// Every request is accepted in its cycle. A read returns one response the cycle
// after it is accepted.
// Build option: define GPIO_CSR_IRQ_EN to include the interrupt logic, which is
// IRQ_EN, IRQ_PEND, rising-edge detection and irq_o. Without it, irq_o is tied
// low. The two interrupt offsets then read as 0 and ignore writes.
module gpio_csr #(
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          GPIO_WIDTH = 32,
    parameter int          NUM_PORTS  = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             bus_req_i,
    input  logic                             bus_we_i,
    input  logic [31:0]                      bus_addr_bi,
    input  logic [3:0]                       bus_be_bi,
    input  logic [31:0]                      bus_wdata_bi,
    output logic                             bus_ack_o,
    output logic                             bus_resp_o,
    output logic [31:0]                      bus_rdata_bo,
    input  logic [NUM_PORTS*GPIO_WIDTH-1:0]  gpio_bi,
    output logic [NUM_PORTS*GPIO_WIDTH-1:0]  gpio_bo,
    output logic                             irq_o
);

    localparam int PW = NUM_PORTS * GPIO_WIDTH;

    // Bus qualification shared by all ports.
    logic        rd_acc;
    logic        wr_acc;
    logic [31:0] lane_mask;

    assign bus_ack_o = bus_req_i;
    assign rd_acc    = bus_req_i & ~bus_we_i;
    assign wr_acc    = bus_req_i & bus_we_i;
    assign lane_mask = {{8{bus_be_bi[3]}}, {8{bus_be_bi[2]}},
                        {8{bus_be_bi[1]}}, {8{bus_be_bi[0]}}};

    // Two-flop synchroniser for the asynchronous pin inputs.
    logic [PW-1:0] sync1_q;
    logic [PW-1:0] sync2_q;

    // Shift pins through both synchroniser stages; reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_bi;
            sync2_q <= sync1_q;
        end
    end

    // Each port contributes its read data, which is zero unless addressed.
    logic [NUM_PORTS-1:0][31:0] port_rdata;
    logic [NUM_PORTS-1:0]       port_irq;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            localparam logic [31:0] PORT_BASE = BASE_ADDR + 32'(16 * gi);

            logic                  sel_out;
            logic                  sel_in;
            logic [GPIO_WIDTH-1:0] in_val;
            logic [GPIO_WIDTH-1:0] out_q;
            logic [GPIO_WIDTH-1:0] out_d;
            logic [31:0]           out_ext;
            logic [31:0]           out_wr;
            logic [31:0]           rdata_p;

            // Decoding compares the whole 32-bit address, so aliases never hit.
            assign sel_out = (bus_addr_bi == PORT_BASE);
            assign sel_in  = (bus_addr_bi == PORT_BASE + 32'h4);
            assign in_val  = sync2_q[gi*GPIO_WIDTH +: GPIO_WIDTH];

            // OUT byte-lane merge. Bits at or above GPIO_WIDTH are dropped on the way back in.
            always_comb begin
                out_ext                   = '0;
                out_ext[GPIO_WIDTH-1:0]   = out_q;
                out_wr                    = (out_ext & ~lane_mask) | (bus_wdata_bi & lane_mask);
                out_d                     = out_q;
                if (wr_acc && sel_out) begin
                    out_d = out_wr[GPIO_WIDTH-1:0];
                end
            end

            // OUT register.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    out_q <= '0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign gpio_bo[gi*GPIO_WIDTH +: GPIO_WIDTH] = out_q;

`ifdef GPIO_CSR_IRQ_EN
            logic                  sel_en;
            logic                  sel_pend;
            logic [GPIO_WIDTH-1:0] prev_q;
            logic [GPIO_WIDTH-1:0] rise;
            logic [GPIO_WIDTH-1:0] en_q;
            logic [GPIO_WIDTH-1:0] en_d;
            logic [GPIO_WIDTH-1:0] pend_q;
            logic [GPIO_WIDTH-1:0] pend_d;
            logic [31:0]           en_ext;
            logic [31:0]           en_wr;
            logic [31:0]           clr_ext;

            assign sel_en   = (bus_addr_bi == PORT_BASE + 32'h8);
            assign sel_pend = (bus_addr_bi == PORT_BASE + 32'hC);

            // Both prev_q and the synchroniser are cleared by reset, so the first cycle after release sees no edge.
            assign rise = in_val & ~prev_q;

            // IRQ_EN lane merge, then W1C clear. A same-cycle rising edge wins over the clear.
            always_comb begin
                en_ext                  = '0;
                en_ext[GPIO_WIDTH-1:0]  = en_q;
                en_wr                   = (en_ext & ~lane_mask) | (bus_wdata_bi & lane_mask);
                en_d                    = en_q;
                if (wr_acc && sel_en) begin
                    en_d = en_wr[GPIO_WIDTH-1:0];
                end
                clr_ext = '0;
                if (wr_acc && sel_pend) begin
                    clr_ext = bus_wdata_bi & lane_mask;
                end
                pend_d = (pend_q & ~clr_ext[GPIO_WIDTH-1:0]) | rise;
            end

            // Edge history, enable and pending registers.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    prev_q <= '0;
                    en_q   <= '0;
                    pend_q <= '0;
                end else begin
                    prev_q <= in_val;
                    en_q   <= en_d;
                    pend_q <= pend_d;
                end
            end

            assign port_irq[gi] = |(pend_q & en_q);

            // Read mux for this port, including the interrupt registers.
            always_comb begin
                rdata_p = '0;
                if (sel_out) begin
                    rdata_p[GPIO_WIDTH-1:0] = out_q;
                end else if (sel_in) begin
                    rdata_p[GPIO_WIDTH-1:0] = in_val;
                end else if (sel_en) begin
                    rdata_p[GPIO_WIDTH-1:0] = en_q;
                end else if (sel_pend) begin
                    rdata_p[GPIO_WIDTH-1:0] = pend_q;
                end
            end
`else
            assign port_irq[gi] = 1'b0;

            // Read mux for this port. The interrupt offsets fall through to zero.
            always_comb begin
                rdata_p = '0;
                if (sel_out) begin
                    rdata_p[GPIO_WIDTH-1:0] = out_q;
                end else if (sel_in) begin
                    rdata_p[GPIO_WIDTH-1:0] = in_val;
                end
            end
`endif

            assign port_rdata[gi] = rdata_p;
        end
    endgenerate

    // Combine the per-port read data. At most one port is addressed, so OR acts as a mux.
    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_data = rd_data | port_rdata[p];
        end
    end

    // Read response pipeline: one cycle after acceptance, with zero data when idle.
    logic        resp_q;
    logic [31:0] rdata_q;

    // Register the response. A read accepted during reset is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= rd_acc;
            rdata_q <= rd_acc ? rd_data : 32'h0;
        end
    end

    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;

`ifdef GPIO_CSR_IRQ_EN
    logic irq_q;

    // The interrupt request lags the pending/enable registers by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |port_irq;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq;
    assign unused_irq = |port_irq;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_csr.sv
// Bench for gpio_csr. dut0 uses the default parameters (1 port x 32 bits).
// dut1 uses 2 ports x 8 bits. Read expectations go into per-DUT queues, and a
// negedge monitor pops them, checking both the data and the response cycle.
module tb_gpio_csr;

    localparam logic [31:0] B = 32'h80000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];

    logic        ack0, resp0, irq0;
    logic [31:0] rdata0;
    logic [31:0] gpio_bi0, gpio_bo0;
    logic        ack1, resp1, irq1;
    logic [31:0] rdata1;
    logic [15:0] gpio_bi1, gpio_bo1;

    gpio_csr dut0 (
        .clk_i(clk), .rst_i(rst[0]), .bus_req_i(req[0]), .bus_we_i(we[0]),
        .bus_addr_bi(addr[0]), .bus_be_bi(be[0]), .bus_wdata_bi(wdata[0]),
        .bus_ack_o(ack0), .bus_resp_o(resp0), .bus_rdata_bo(rdata0),
        .gpio_bi(gpio_bi0), .gpio_bo(gpio_bo0), .irq_o(irq0)
    );

    gpio_csr #(.BASE_ADDR(32'h80000000), .GPIO_WIDTH(8), .NUM_PORTS(2)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .bus_req_i(req[1]), .bus_we_i(we[1]),
        .bus_addr_bi(addr[1]), .bus_be_bi(be[1]), .bus_wdata_bi(wdata[1]),
        .bus_ack_o(ack1), .bus_resp_o(resp1), .bus_rdata_bo(rdata1),
        .gpio_bi(gpio_bi1), .gpio_bo(gpio_bo1), .irq_o(irq1)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    function automatic void mon(input int s, input logic resp, input logic [31:0] rd);
        exp_t e;
        int   qs;
        qs = (s == 0) ? q0.size() : q1.size();
        if (resp) begin
            if (qs == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp dut%0d: got resp=1 rdata=%h, required no response", s, rd);
            end else begin
                if (s == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                $display("RSP dut%0d %s data=%h cyc=%0d", s, e.name, rd, cyc);
                chk({e.name, "_data"}, rd, e.data);
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end else begin
            chk($sformatf("idle_rdata_dut%0d", s), rd, 32'h0);
        end
    endfunction

    // Response monitor, sampling away from the active edge.
    always @(negedge clk) begin
        mon(0, resp0, rdata0);
        mon(1, resp1, rdata1);
    end

    task automatic bus_wr(input int s, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req[s] = 1'b1; we[s] = 1'b1; addr[s] = a; be[s] = b; wdata[s] = d;
        $display("WR  dut%0d addr=%h be=%b data=%h", s, a, b, d);
        #1;
        chk("ack_wr", (s == 0) ? ack0 : ack1, 1'b1);
        @(negedge clk);
        req[s] = 1'b0; we[s] = 1'b0;
    endtask

    task automatic bus_rd(input int s, input logic [31:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        req[s] = 1'b1; we[s] = 1'b0; addr[s] = a; be[s] = 4'h0; wdata[s] = 32'h0;
        $display("RD  dut%0d addr=%h (%s)", s, a, name);
        if (!rst[s]) begin
            e.data = exp; e.cyc = cyc + 1; e.name = name;
            if (s == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        #1;
        chk("ack_rd", (s == 0) ? ack0 : ack1, 1'b1);
        @(negedge clk);
        req[s] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
            addr[i] = '0; be[i] = '0; wdata[i] = '0;
        end
        gpio_bi0 = '0;
        gpio_bi1 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_gpio_bo0", gpio_bo0, 32'h0);
        chk("rst_irq0", irq0, 1'b0);
        chk("rst_resp0", resp0, 1'b0);
        chk("rst_gpio_bo1", gpio_bo1, 16'h0);
        chk("rst_irq1", irq1, 1'b0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // OUT writes with byte enables
        bus_wr(0, B, 4'b1111, 32'hA5A5A5A5);
        bus_wr(0, B, 4'b0001, 32'h00000011);
        chk("out_be0001", gpio_bo0, 32'hA5A5A511);
        bus_rd(0, B, 32'hA5A5A511, "rd_out1");
        bus_wr(0, B, 4'b1010, 32'h12345678);
        chk("out_be1010", gpio_bo0, 32'h12A55611);

        // IN is read-only, and pins reach IN after synchronisation
        gpio_bi0 = 32'h0000F00D;
        bus_wr(0, B + 32'h4, 4'b1111, 32'hFFFFFFFF);
        chk("ro_write_ignored", gpio_bo0, 32'h12A55611);
        idle(3);

        // Back-to-back reads, including unmapped addresses
        bus_rd(0, B, 32'h12A55611, "b2b_out");
        bus_rd(0, B + 32'h4, 32'h0000F00D, "b2b_in");
        bus_rd(0, 32'h80000100, 32'h0, "unmapped_100");
        bus_rd(0, B + 32'h10, 32'h0, "unmapped_port1");
        bus_rd(0, 32'h00000000, 32'h0, "alias_zero");
        bus_wr(0, 32'h80000010, 4'b1111, 32'h0);
        bus_wr(0, 32'h00000000, 4'b1111, 32'h0);
        chk("unmapped_write_ignored", gpio_bo0, 32'h12A55611);

`ifdef GPIO_CSR_IRQ_EN
        gpio_bi0 = 32'h0;
        idle(4);
        bus_wr(0, B + 32'hC, 4'b1111, 32'hFFFFFFFF);
        bus_rd(0, B + 32'hC, 32'h0, "pend_cleared");
        bus_wr(0, B + 32'h8, 4'b1111, 32'h1);
        bus_rd(0, B + 32'h8, 32'h1, "irq_en_rd");
        chk("irq_quiet", irq0, 1'b0);
        gpio_bi0 = 32'h1;
        idle(5);
        bus_rd(0, B + 32'hC, 32'h1, "pend_set");
        chk("irq_asserted", irq0, 1'b1);
        bus_wr(0, B + 32'hC, 4'b1111, 32'h1);
        chk("irq_lag", irq0, 1'b1);
        @(negedge clk);
        chk("irq_cleared", irq0, 1'b0);
        bus_rd(0, B + 32'hC, 32'h0, "pend_w1c");

        // A W1C that lands in the same cycle as a synchronised rising edge
        gpio_bi0 = 32'h0;
        idle(4);
        gpio_bi0 = 32'h1;
        @(negedge clk);
        @(negedge clk);
        bus_wr(0, B + 32'hC, 4'b1111, 32'h1);
        bus_rd(0, B + 32'hC, 32'h1, "pend_edge_wins");
        chk("irq_after_race", irq0, 1'b1);
        bus_wr(0, B + 32'hC, 4'b1110, 32'h1);
        bus_rd(0, B + 32'hC, 32'h1, "pend_lane_off");
        bus_wr(0, B + 32'hC, 4'b0001, 32'h1);
        bus_rd(0, B + 32'hC, 32'h0, "pend_lane_on");
`else
        bus_wr(0, B + 32'h8, 4'b1111, 32'hFFFFFFFF);
        bus_wr(0, B + 32'hC, 4'b1111, 32'hFFFFFFFF);
        bus_rd(0, B + 32'h8, 32'h0, "no_irq_en");
        bus_rd(0, B + 32'hC, 32'h0, "no_irq_pend");
        gpio_bi0 = 32'h0;
        idle(3);
        gpio_bi0 = 32'h1;
        idle(5);
        chk("irq_tied_low", irq0, 1'b0);
`endif

        // Two 8-bit ports
        bus_wr(1, B + 32'h10, 4'b1111, 32'h0000FFFF);
        chk("p1_out", gpio_bo1, 16'hFF00);
        bus_rd(1, B + 32'h10, 32'h000000FF, "p1_rd");
        bus_rd(1, B, 32'h0, "p0_rd_zero");
        bus_wr(1, B, 4'b0011, 32'h00001234);
        chk("p0_out_trunc", gpio_bo1, 16'hFF34);
        bus_rd(1, B, 32'h00000034, "p0_rd");
        gpio_bi1 = 16'hA55A;
        idle(3);
        bus_rd(1, B + 32'h4, 32'h0000005A, "p0_in");
        bus_rd(1, B + 32'h14, 32'h000000A5, "p1_in");
        bus_rd(1, B + 32'h20, 32'h0, "port2_unmapped");

        // Reset asserted while a read is issued
        rst[1] = 1'b1;
        bus_rd(1, B + 32'h10, 32'h0, "rd_in_reset");
        chk("rst_mid_resp", resp1, 1'b0);
        chk("rst_mid_rdata", rdata1, 32'h0);
        chk("rst_mid_gpio", gpio_bo1, 16'h0);
        chk("rst_mid_irq", irq1, 1'b0);
        rst[1] = 1'b0;
        @(negedge clk);
        bus_rd(1, B + 32'h10, 32'h0, "p1_after_rst");

        idle(4);
        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_csr.md
GPIO_CSR -- requirements
Module: gpio_csr

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h80000000, meaning byte address of port 0 register block.
REQ-002 SHALL have parameter GPIO_WIDTH, default 32, meaning bits per port (legal 1..32).
REQ-003 SHALL have parameter NUM_PORTS, default 1, meaning number of GPIO ports (legal 1..4).
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port bus_req_i  input  1  bus request.
REQ-007 SHALL have port bus_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port bus_addr_bi  input  32  byte address.
REQ-009 SHALL have port bus_be_bi  input  4  write byte enables.
REQ-010 SHALL have port bus_wdata_bi  input  32  write data.
REQ-011 SHALL have port bus_ack_o  output  1  request accepted.
REQ-012 SHALL have port bus_resp_o  output  1  read response valid.
REQ-013 SHALL have port bus_rdata_bo  output  32  read data.
REQ-014 SHALL have port gpio_bi  input  NUM_PORTS*GPIO_WIDTH  asynchronous inputs; port p at bits [p*GPIO_WIDTH +: GPIO_WIDTH].
REQ-015 SHALL have port gpio_bo  output  NUM_PORTS*GPIO_WIDTH  output registers, same packing.
REQ-016 SHALL have port irq_o  output  1  level interrupt request.

Function
REQ-017 SHALL map port p at BASE_ADDR+16*p: +0x0 OUT (RW), +0x4 IN (RO), +0x8 IRQ_EN (RW), +0xC IRQ_PEND (RW1C); decoding uses the full 32-bit address.
REQ-018 SHALL drive bus_ack_o = bus_req_i combinationally; every request is accepted in its cycle.
REQ-019 SHALL, for each accepted read, pulse bus_resp_o for exactly one cycle, the cycle after acceptance; writes produce no response.
REQ-020 SHALL respond to reads of unmapped addresses with resp and rdata 0; writes to unmapped or RO addresses are ignored.
REQ-021 SHALL drive bus_rdata_bo to 0 whenever bus_resp_o is 0.
REQ-022 SHALL apply writes to OUT/IRQ_EN per byte lane where bus_be_bi[i] = 1; unenabled lanes are unchanged.
REQ-023 SHALL read register bits at or above GPIO_WIDTH as 0 and discard writes to them.
REQ-024 SHALL synchronise gpio_bi through two flops per bit; IN returns the second-stage value (2-cycle pin-to-register latency).
REQ-025 SHALL set IRQ_PEND[b] on a clock edge where synchronised bit b is 1 and its previous-cycle value is 0 (rising edge).
REQ-026 SHALL clear IRQ_PEND bits written with 1 (byte-enabled lanes only); a same-cycle rising edge SHALL win and leave the bit set.
REQ-027 SHALL drive irq_o registered as OR over all ports of (IRQ_PEND & IRQ_EN); one-cycle delay from the register update.
REQ-028 SHALL accept back-to-back reads on consecutive cycles with one response per read, in order.

Reset
REQ-029 SHALL, while rst_i is 1, clear OUT, IRQ_EN, IRQ_PEND, synchroniser and edge-history flops; gpio_bo, bus_resp_o, bus_rdata_bo and irq_o SHALL read 0 the cycle after rst_i is sampled high.
REQ-030 SHALL drop any read accepted in a cycle where rst_i is 1 (no response); no edge SHALL be detected in the first cycle after reset release.

Configuration
REQ-031 SHALL, with macro GPIO_CSR_IRQ_EN defined, implement IRQ_EN, IRQ_PEND, edge detection and irq_o as specified.
REQ-032 SHALL, without GPIO_CSR_IRQ_EN, omit that logic: irq_o tied 0, offsets +0x8/+0xC read 0 with a response and ignore writes.

Verification
REQ-033 SHALL cover: write 0xA5A5A5A5 be=4'b1111 to BASE_ADDR, then be=4'b0001 data 0x00000011 -> gpio_bo = 0xA5A5A511; read returns same with resp one cycle after req.
REQ-034 SHALL cover: gpio_bi = 0x0000F00D held -> read of BASE_ADDR+4 issued 3+ cycles later returns 0x0000F00D; read of 0x80000100 returns resp with 0.
REQ-035 SHALL cover (IRQ_EN build): IRQ_EN=0x1, gpio_bi[0] 0->1 -> IRQ_PEND=0x1 and irq_o=1; write 0x1 to +0xC -> irq_o=0 next cycle after update.
REQ-036 SHALL cover: W1C of IRQ_PEND[0] in the same cycle as a synchronised rising edge on bit 0 -> IRQ_PEND[0] stays 1.
REQ-037 SHALL cover: NUM_PORTS=2, GPIO_WIDTH=8: write 0xFFFF to BASE_ADDR+16 -> gpio_bo = 16'hFF00, readback 0x000000FF; rst_i pulsed mid-read -> no resp, all outputs 0.
